// File: rtl/ctrl_pkg.sv
// Shared control definitions for the multicycle ARM controller and datapath.
// Holds the controller state encoding and the select encodings used by the
// ALU operand muxes and the result mux.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        ALUWB2   = 4'd9,
        BRANCH   = 4'd10,
        UNKNOWN  = 4'd11
    } state_t;

    localparam logic [1:0] SRCA_RN       = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT   = 2'b10;

    localparam logic [1:0] SRCB_RM       = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_ALUOUT2   = 2'b11;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Memory-side handshake between the controller and instruction/data memory.
//   mem_ready : memory completes the current access this cycle
//   AdrSrc    : 0 = PC, 1 = ALUOut drives the memory address
//   MemW      : memory write enable (before condition check)
//   IRWrite   : load the instruction register from read data
interface mc_control_fsm_if;
    logic mem_ready;
    logic AdrSrc;
    logic MemW;
    logic IRWrite;

    modport master (input mem_ready, output AdrSrc, output MemW, output IRWrite);
    modport slave  (output mem_ready, input AdrSrc, input MemW, input IRWrite);
endinterface

// File: rtl/mc_control_fsm.sv
// Main multicycle control FSM: fetch/decode/execute/memory/writeback
// sequencing plus a second writeback cycle for the long-multiply high word.
//   clk, reset      : clock, synchronous active-low reset
//   mem             : memory handshake (mem_ready in; AdrSrc, MemW, IRWrite out)
//   op, funct       : instruction fields, sampled in DECODE / MEMADR
//   mul_long        : UMULL/SMULL flag, sampled in ALUWB
//   NextPC .. Branch: datapath selects and enables
//   state           : current state (debug)
//   retired         : instructions returned to FETCH, wraps
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 computed, wait for mem_ready
// DECODE   | register read, PC+8 formed, dispatch on op
// MEMADR   | compute Rn + ExtImm load/store address
// MEMRD    | read data memory, wait for mem_ready
// MEMWB    | write ReadData to Rd
// MEMWR    | write data memory, held until mem_ready
// EXECUTER | ALU op with register operand
// EXECUTEI | ALU op with immediate operand
// ALUWB    | write ALUOut to Rd
// ALUWB2   | write ALUOut2 to RdHi (long multiply only)
// BRANCH   | PC + offset
// UNKNOWN  | undefined op, sticky until reset
module mc_control_fsm
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master mem,
    input  logic [1:0]       op,
    input  logic [5:0]       funct,
    input  logic             mul_long,
    output logic             NextPC,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ALUOp,
    output logic [1:0]       ResultSrc,
    output logic             RegW,
    output logic             RegHiSel,
    output logic             Branch,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  retired_q;
    logic              irwrite, adrsrc, memw;
    logic              unused_funct;

    assign unused_funct = ^funct[4:1];

    always_comb begin
        state_d   = state_q;
        irwrite   = 1'b0;
        NextPC    = 1'b0;
        adrsrc    = 1'b0;
        ALUSrcA   = SRCA_RN;
        ALUSrcB   = SRCB_RM;
        ALUOp     = 1'b0;
        ResultSrc = RES_ALUOUT;
        RegW      = 1'b0;
        RegHiSel  = 1'b0;
        memw      = 1'b0;
        Branch    = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (mem.mem_ready) begin
                    irwrite = 1'b1;
                    NextPC  = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (op)
                    2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = UNKNOWN;
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_RN;
                ALUSrcB = SRCB_EXTIMM;
                state_d = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adrsrc = 1'b1;
                if (mem.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_READDATA;
                RegW      = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                adrsrc = 1'b1;
                memw   = 1'b1;
                if (mem.mem_ready) state_d = FETCH;
            end
            EXECUTER, EXECUTEI: begin
                ALUSrcA = SRCA_RN;
                ALUSrcB = (state_q == EXECUTEI) ? SRCB_EXTIMM : SRCB_RM;
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegW      = 1'b1;
                state_d   = mul_long ? ALUWB2 : FETCH;
            end
            ALUWB2: begin
                ResultSrc = RES_ALUOUT2;
                RegHiSel  = 1'b1;
                RegW      = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = SRCA_ALUOUT;
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
                Branch    = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = UNKNOWN;
        endcase
        // Suppress all architectural writes while reset is held, even if the
        // register still shows a write state from before reset.
        if (!reset) begin
            irwrite = 1'b0;
            NextPC  = 1'b0;
            RegW    = 1'b0;
            memw    = 1'b0;
            Branch  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == FETCH && state_q != FETCH)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign mem.IRWrite = irwrite;
    assign mem.AdrSrc  = adrsrc;
    assign mem.MemW    = memw;
    assign state       = state_q;
    assign retired     = retired_q;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Main multicycle control state machine for the ARM datapath. Sequences fetch, decode, execute, memory and writeback for each instruction, and drives the select and enable signals around the ALU: the ALU operand selects, the ALU-op decode enable, and result selection. Adds a second writeback cycle so the ALU's upper-half long-multiply result (UMULL/SMULL) reaches the register file. Honours a memory ready handshake.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low
- op  in  2  instruction op field, sampled in DECODE
- funct  in  6  instruction funct field (funct[5]=immediate, funct[0]=load/S)
- mul_long  in  1  decoder flag: current instruction is UMULL/SMULL, sampled in ALUWB
- mem_ready  in  1  memory completes access this cycle
- IRWrite  out  1  load instruction register
- NextPC  out  1  PC write enable (ORed with branch-taken outside)
- AdrSrc  out  1  0=PC, 1=ALUOut to memory address
- ALUSrcA  out  2  00=Rn, 01=PC, 10=ALUOut
- ALUSrcB  out  2  00=Rm, 01=ExtImm, 10=constant 4
- ALUOp  out  1  1 = ALU decoder uses funct; 0 = add
- ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult, 11=ALUOut2 (Result2 register)
- RegW  out  1  register-file write enable (pre-condition-check)
- RegHiSel  out  1  1 = write address is RdHi (second long-multiply write)
- MemW  out  1  memory write enable (pre-condition-check)
- Branch  out  1  branch state
- state  out  4  current state, for debug
- retired  out  CNT_W  count of instructions returning to FETCH

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, ALUWB2 9, BRANCH 10, UNKNOWN 11.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite and NextPC are asserted only when mem_ready=1. Go to DECODE on mem_ready; otherwise stay.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Branch on op:
  - op=00 → EXECUTER if funct[5]=0, EXECUTEI if funct[5]=1
  - op=01 → MEMADR
  - op=10 → BRANCH
  - op=11 → UNKNOWN
- MEMADR: ALUSrcA=00, ALUSrcB=01. Go to MEMRD if funct[0]=1, else MEMWR.
- MEMRD: AdrSrc=1. Stay until mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Go to FETCH.
- MEMWR: AdrSrc=1, MemW=1, held until mem_ready. Go to FETCH in the cycle mem_ready=1.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1. EXECUTEI: the same except ALUSrcB=01. Both go to ALUWB.
- ALUWB: ResultSrc=00, RegW=1. Go to ALUWB2 if mul_long, else FETCH.
- ALUWB2: ResultSrc=11, RegHiSel=1, RegW=1. Go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1. Go to FETCH.
- UNKNOWN: all enables 0. Sticky until reset.
- Outputs not listed for a state are 0.
- retired increments by 1 on every transition into FETCH from another state. It wraps modulo 2^CNT_W.

## Timing
- Moore outputs decoded from the state register. The exceptions are IRWrite, NextPC (FETCH) and the state-exit conditions, which depend combinationally on mem_ready.
- Cycles per instruction with mem_ready always 1:
  - data-processing: 4
  - long multiply: 5
  - LDR: 5
  - STR: 4
  - B: 3
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Reset (reset=0 at a clock edge): state←FETCH, retired←0.
- While reset=0, IRWrite, NextPC, RegW, MemW and Branch are forced to 0 combinationally. This holds even mid-MEMWR, so no write is issued.
- The first fetch is in the cycle after reset returns to 1.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- No output X after reset for any op/funct value.

## Structure
- Shared package ctrl_pkg holds:
  - the state enum with the encodings above
  - named constants for ALUSrcA, ALUSrcB and ResultSrc encodings, shared with the datapath muxes and the ALU decoder
- No sub-module. The next-state logic, output decode and retired counter live in one module.

## Test plan
- Reset, then ADD register (op=00, funct=000000), mem_ready=1 → states 0,1,6,8,0; RegW=1 only in state 8; retired=1.
- UMULL with mul_long=1 → states 0,1,6,8,9,0; the state-9 cycle has RegW=1, RegHiSel=1, ResultSrc=11.
- LDR (op=01, funct[0]=1), mem_ready low 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; RegW only in state 4.
- STR with reset driven 0 during MEMWR → MemW=0 that cycle; state=0 and retired=0 next cycle.
- B (op=10) → 3 cycles, Branch=1 only in state 10. Then op=11 → state 11 is held, with no enables, until reset.
